// File: rtl/align_rshift_pipe_if.sv
// Handshake bundle for align_rshift_pipe.
//
// Purpose: carries the input (operand, shift amount, arith flag, tag) and
// output (result, sticky, tag) transactions of the alignment shifter, each
// with its own valid/ready pair.
//
// Signals:
//   in_valid / in_ready   input transaction handshake
//   in_data               operand to shift (WIDTH bits)
//   in_shift              unsigned right-shift amount (SHIFT_W bits)
//   in_arith              1 = sign-fill, 0 = zero-fill
//   in_tag                sideband returned with the result (TAG_W bits)
//   out_valid / out_ready result handshake
//   out_data              shifted result
//   out_sticky            OR of all bits shifted out
//   out_tag               tag of the current result
//
// Modports: master = environment side (drives inputs, accepts results),
//           slave  = shifter side.
interface align_rshift_pipe_if #(
    parameter int WIDTH   = 26,
    parameter int SHIFT_W = 8,
    parameter int TAG_W   = 4
);
    logic               in_valid;
    logic               in_ready;
    logic [WIDTH-1:0]   in_data;
    logic [SHIFT_W-1:0] in_shift;
    logic               in_arith;
    logic [TAG_W-1:0]   in_tag;
    logic               out_valid;
    logic               out_ready;
    logic [WIDTH-1:0]   out_data;
    logic               out_sticky;
    logic [TAG_W-1:0]   out_tag;

    modport master (
        output in_valid, in_data, in_shift, in_arith, in_tag, out_ready,
        input  in_ready, out_valid, out_data, out_sticky, out_tag
    );

    modport slave (
        input  in_valid, in_data, in_shift, in_arith, in_tag, out_ready,
        output in_ready, out_valid, out_data, out_sticky, out_tag
    );
endinterface

// File: rtl/align_rshift_pipe.sv
// Pipelined mantissa-alignment right shifter.
//
// Purpose: shifts the smaller operand's mantissa right by the exponent
// difference. A SHIFT_W-level binary barrel (level k shifts by 2^k) is spread
// over PIPE register stages; stage s applies levels
// floor(s*SHIFT_W/PIPE) .. floor((s+1)*SHIFT_W/PIPE)-1. Shift amounts of
// WIDTH or more saturate to all fill bits. Latency is PIPE cycles; the whole
// pipe stalls together when the result is not taken.
//
// Parameters: WIDTH (data bits), SHIFT_W (shift bits), PIPE (stages,
// 1..SHIFT_W), TAG_W (tag bits). Interface parameters must match.
//
// Ports:
//   clk    rising-edge clock
//   reset  asynchronous active-low reset; clears valids and the out_* values
//   bus    align_rshift_pipe_if.slave (in_* / out_* handshake bundle)
//
// Build option: define ALIGN_RSHIFT_STICKY_EN to build the sticky (OR of
// shifted-out bits) path; without it out_sticky is tied to 0.
module align_rshift_pipe #(
    parameter int WIDTH   = 26,
    parameter int SHIFT_W = 8,
    parameter int PIPE    = 2,
    parameter int TAG_W   = 4
) (
    input  logic               clk,
    input  logic               reset,
    align_rshift_pipe_if.slave bus
);
    localparam logic [WIDTH-1:0] ONES = '1;

    logic advance;
    logic accept;

    // One barrel level: shift by 2^k, filling from the top with 'fill'.
    function automatic logic [WIDTH-1:0] shift_level(input logic [WIDTH-1:0] d,
                                                     input logic fill, input int k);
        int amt;
        if (k >= 31) return {WIDTH{fill}};
        amt = 1 << k;
        if (amt >= WIDTH) return {WIDTH{fill}};
        return (d >> amt) | ({WIDTH{fill}} & ~(ONES >> amt));
    endfunction

    // Levels lo..hi-1 of the barrel, selected by the shift bits.
    function automatic logic [WIDTH-1:0] shift_levels(input logic [WIDTH-1:0] d,
                                                      input logic fill,
                                                      input logic [SHIFT_W-1:0] sh,
                                                      input int lo, input int hi);
        logic [WIDTH-1:0] r;
        r = d;
        for (int k = 0; k < SHIFT_W; k++) begin
            if (k >= lo && k < hi && sh[k]) r = shift_level(r, fill, k);
        end
        return r;
    endfunction

`ifdef ALIGN_RSHIFT_STICKY_EN
    // Bits lost by one level. Fill bits only fall off the bottom once the
    // total shift exceeds WIDTH, and then the sign bit itself was already
    // shifted out, so accumulating per level matches the OR of the operand.
    function automatic logic sticky_level(input logic [WIDTH-1:0] d, input int k);
        int amt;
        if (k >= 31) return |d;
        amt = 1 << k;
        if (amt >= WIDTH) return |d;
        return |(d & ~(ONES << amt));
    endfunction

    function automatic logic sticky_levels(input logic [WIDTH-1:0] d,
                                           input logic fill,
                                           input logic [SHIFT_W-1:0] sh,
                                           input int lo, input int hi);
        logic [WIDTH-1:0] r;
        logic             s;
        r = d;
        s = 1'b0;
        for (int k = 0; k < SHIFT_W; k++) begin
            if (k >= lo && k < hi && sh[k]) begin
                s = s | sticky_level(r, k);
                r = shift_level(r, fill, k);
            end
        end
        return s;
    endfunction
`endif

    // Global stall: every stage moves only when the output slot frees up.
    assign advance      = !bus.out_valid || bus.out_ready;
    assign accept       = bus.in_valid && advance;
    assign bus.in_ready = advance;

    for (genvar s = 0; s < PIPE; s++) begin : stg
        localparam int LO = (s * SHIFT_W) / PIPE;
        localparam int HI = ((s + 1) * SHIFT_W) / PIPE;

        logic [WIDTH-1:0]   d_in;
        logic [SHIFT_W-1:0] sh_in;
        logic               fill_in;
        logic [TAG_W-1:0]   tag_in;
        logic               vld_in;
        logic [WIDTH-1:0]   d_nxt;
        logic [WIDTH-1:0]   d_q;
        logic [TAG_W-1:0]   tag_q;
        logic               vld_q;

        if (s == 0) begin : src
            assign d_in    = bus.in_data;
            assign sh_in   = bus.in_shift;
            assign fill_in = bus.in_arith & bus.in_data[WIDTH-1];
            assign tag_in  = bus.in_tag;
            assign vld_in  = accept;
        end else begin : src
            assign d_in    = stg[s-1].d_q;
            assign sh_in   = carry[s-1].sh_q;
            assign fill_in = carry[s-1].fill_q;
            assign tag_in  = stg[s-1].tag_q;
            assign vld_in  = stg[s-1].vld_q;
        end

        assign d_nxt = shift_levels(d_in, fill_in, sh_in, LO, HI);

        // ---- stage s register boundary ----
        if (s == PIPE - 1) begin : regs
            // Output stage: result and tag are cleared by reset as well.
            always_ff @(posedge clk or negedge reset) begin
                if (!reset) begin
                    vld_q <= 1'b0;
                    d_q   <= '0;
                    tag_q <= '0;
                end else if (advance) begin
                    vld_q <= vld_in;
                    d_q   <= d_nxt;
                    tag_q <= tag_in;
                end
            end
        end else begin : regs
            always_ff @(posedge clk or negedge reset) begin
                if (!reset)       vld_q <= 1'b0;
                else if (advance) vld_q <= vld_in;
            end

            always_ff @(posedge clk) begin
                if (advance) begin
                    d_q   <= d_nxt;
                    tag_q <= tag_in;
                end
            end
        end

`ifdef ALIGN_RSHIFT_STICKY_EN
        logic stk_in;
        logic stk_nxt;
        logic stk_q;

        if (s == 0) begin : stk_src
            assign stk_in = 1'b0;
        end else begin : stk_src
            assign stk_in = stg[s-1].stk_q;
        end

        assign stk_nxt = stk_in | sticky_levels(d_in, fill_in, sh_in, LO, HI);

        if (s == PIPE - 1) begin : stk_reg
            always_ff @(posedge clk or negedge reset) begin
                if (!reset)       stk_q <= 1'b0;
                else if (advance) stk_q <= stk_nxt;
            end
        end else begin : stk_reg
            always_ff @(posedge clk) begin
                if (advance) stk_q <= stk_nxt;
            end
        end
`endif
    end

    // Remaining shift bits and fill bit travel only to stages that still
    // have barrel levels to apply.
    for (genvar s = 0; s < PIPE - 1; s++) begin : carry
        logic [SHIFT_W-1:0] sh_q;
        logic               fill_q;

        always_ff @(posedge clk) begin
            if (advance) begin
                sh_q   <= stg[s].sh_in;
                fill_q <= stg[s].fill_in;
            end
        end
    end

    assign bus.out_valid = stg[PIPE-1].vld_q;
    assign bus.out_data  = stg[PIPE-1].d_q;
    assign bus.out_tag   = stg[PIPE-1].tag_q;
`ifdef ALIGN_RSHIFT_STICKY_EN
    assign bus.out_sticky = stg[PIPE-1].stk_q;
`else
    assign bus.out_sticky = 1'b0;
`endif
endmodule
